// File: rtl/pipe_pkg.sv
// pipe_pkg: shared update codes, PC-select codes, controller state and hazard rule.
package pipe_pkg;
  localparam logic [1:0] UPD_HOLD  = 2'b00;
  localparam logic [1:0] UPD_ADV   = 2'b01;
  localparam logic [1:0] UPD_FLUSH = 2'b10;
  localparam logic [1:0] PCS_SEQ  = 2'd0;
  localparam logic [1:0] PCS_JUMP = 2'd1;
  localparam logic [1:0] PCS_EXEC = 2'd2;
  localparam logic [1:0] PCS_NPC  = 2'd3;
  typedef enum logic [1:0] {RUN, WAIT, HALT} ctrl_state_t;
  // Same producer/consumer match the forwarding unit applies.
  function automatic logic hazard_match(input logic [5:0] r, input logic [1:0] rw, input logic [4:0] rd);
    return (rw != 2'b00) && (rw[1] == r[5]) && (rd == r[4:0]);
  endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: flags a decode source waiting on a load still in execute.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [5:0] d_rs,
  input  logic [5:0] d_rt,
  input  logic [1:0] de_rw,
  input  logic [4:0] de_rd,
  input  logic       de_mem_read,
  output logic       load_use
);
  assign load_use = de_mem_read && (hazard_match(d_rs, de_rw, de_rd) || hazard_match(d_rt, de_rw, de_rd));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush controller driving pipeline register update codes and PC control.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int WAIT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        d_rs,
  input  logic [5:0]        d_rt,
  input  logic              d_jump,
  input  logic [1:0]        de_rw,
  input  logic [4:0]        de_rd,
  input  logic              de_mem_read,
  input  logic [WAIT_W-1:0] de_wait_time,
  input  logic              de_stop,
  input  logic [31:0]       de_npc,
  input  logic              e_redirect,
  input  logic              ext_stall,
  input  logic              resume,
  output logic [1:0]        fd_update,
  output logic [1:0]        de_update,
  output logic [1:0]        ew_update,
  output logic              pc_en,
  output logic [1:0]        pc_sel,
  output logic              halted
);
  ctrl_state_t       r_state, w_state_n;
  logic [WAIT_W-1:0] r_cnt, w_cnt_n;
  logic              r_wait_done, w_done_n;
  logic              w_load_use, w_pc_en, w_halted, w_unused;
  logic [1:0]        w_fd, w_de, w_ew, w_pc_sel;
  // The restart PC is muxed outside; only pc_sel selects it here.
  assign w_unused = ^de_npc;
  hazard_detect u_hazard (
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .de_rw      (de_rw),
    .de_rd      (de_rd),
    .de_mem_read(de_mem_read),
    .load_use   (w_load_use)
  );
  always_comb begin
    w_fd      = UPD_HOLD;
    w_de      = UPD_HOLD;
    w_ew      = UPD_HOLD;
    w_pc_en   = 1'b0;
    w_pc_sel  = PCS_SEQ;
    w_halted  = 1'b0;
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_done_n  = r_wait_done;
    case (r_state)
      RUN: begin
        if (ext_stall) begin
          w_fd = UPD_HOLD;
        end else if (de_stop) begin
          {w_fd, w_de, w_ew} = {UPD_FLUSH, UPD_FLUSH, UPD_ADV};
          w_pc_en   = 1'b1;
          w_pc_sel  = PCS_NPC;
          w_state_n = HALT;
        end else if (de_wait_time != '0 && !r_wait_done) begin
          w_ew = UPD_FLUSH;
          if (de_wait_time > WAIT_W'(1)) begin
            w_cnt_n   = de_wait_time - WAIT_W'(1);
            w_state_n = WAIT;
          end else begin
            w_done_n = 1'b1;
          end
        end else if (e_redirect) begin
          {w_fd, w_de, w_ew} = {UPD_FLUSH, UPD_FLUSH, UPD_ADV};
          w_pc_en  = 1'b1;
          w_pc_sel = PCS_EXEC;
        end else if (w_load_use) begin
          {w_fd, w_de, w_ew} = {UPD_HOLD, UPD_FLUSH, UPD_ADV};
        end else if (d_jump) begin
          {w_fd, w_de, w_ew} = {UPD_FLUSH, UPD_ADV, UPD_ADV};
          w_pc_en  = 1'b1;
          w_pc_sel = PCS_JUMP;
        end else begin
          {w_fd, w_de, w_ew} = {UPD_ADV, UPD_ADV, UPD_ADV};
          w_pc_en = 1'b1;
        end
      end
      WAIT: begin
        w_ew = ext_stall ? UPD_HOLD : UPD_FLUSH;
        if (!ext_stall) begin
          w_cnt_n = r_cnt - WAIT_W'(1);
          if (r_cnt == WAIT_W'(1)) begin
            w_state_n = RUN;
            w_done_n  = 1'b1;
          end
        end
      end
      HALT: begin
        w_halted  = 1'b1;
        w_ew      = ext_stall ? UPD_HOLD : UPD_FLUSH;
        w_state_n = resume ? RUN : HALT;
      end
      default: w_state_n = RUN;
    endcase
    // A new instruction entering decode/execute owes its own wait again.
    if (w_de == UPD_ADV || w_de == UPD_FLUSH) w_done_n = 1'b0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      r_wait_done <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_wait_done <= w_done_n;
    end
  end
  assign fd_update = rst ? UPD_HOLD : w_fd;
  assign de_update = rst ? UPD_HOLD : w_de;
  assign ew_update = rst ? UPD_HOLD : w_ew;
  assign pc_en     = !rst && w_pc_en;
  assign pc_sel    = rst ? PCS_SEQ : w_pc_sel;
  assign halted    = !rst && w_halted;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed literal checks plus randomized run against a cycle model.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  d_rs, d_rt;
  logic        d_jump;
  logic [1:0]  de_rw;
  logic [4:0]  de_rd;
  logic        de_mem_read;
  logic [4:0]  de_wait_time;
  logic        de_stop;
  logic [31:0] de_npc;
  logic        e_redirect, ext_stall, resume;
  logic [1:0]  fd_update, de_update, ew_update, pc_sel;
  logic        pc_en, halted;
  logic [9:0]  act;
  int vectors = 0;
  int miscompares = 0;

  pipe_ctrl #(.WAIT_W(5)) dut (
    .clk(clk), .rst(rst), .d_rs(d_rs), .d_rt(d_rt), .d_jump(d_jump),
    .de_rw(de_rw), .de_rd(de_rd), .de_mem_read(de_mem_read),
    .de_wait_time(de_wait_time), .de_stop(de_stop), .de_npc(de_npc),
    .e_redirect(e_redirect), .ext_stall(ext_stall), .resume(resume),
    .fd_update(fd_update), .de_update(de_update), .ew_update(ew_update),
    .pc_en(pc_en), .pc_sel(pc_sel), .halted(halted)
  );

  always #5 clk = ~clk;
  assign act = {fd_update, de_update, ew_update, pc_en, pc_sel, halted};

  function automatic logic [9:0] pack(input int fd, input int de, input int ew, input int en, input int sel, input int h);
    return {2'(fd), 2'(de), 2'(ew), 1'(en), 2'(sel), 1'(h)};
  endfunction

  function automatic bit hit(input logic [5:0] r);
    return de_rw != 2'd0 && de_rw[1] == r[5] && de_rd == r[4:0];
  endfunction

  task automatic check(input string name, input logic [9:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: {fd,de,ew,pc_en,pc_sel,halted} got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk(input string name, input logic [9:0] exp);
    #2 check(name, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_rs = '0; d_rt = '0; d_jump = 0; de_rw = '0; de_rd = '0; de_mem_read = 0;
    de_wait_time = '0; de_stop = 0; de_npc = 32'h100; e_redirect = 0; ext_stall = 0; resume = 0;
  endtask

  // Model: halted flag, stall cycles still owed by the execute instruction, and whether its wait is served.
  initial begin : model
    bit m_halt, n_halt, m_served, n_served;
    int m_busy, n_busy, efd, ede, eew, een, esel, eh;
    m_halt = 0; m_served = 0; m_busy = 0;
    forever begin
      @(negedge clk);
      n_halt = m_halt; n_busy = m_busy; n_served = m_served;
      efd = 0; ede = 0; eew = 0; een = 0; esel = 0; eh = 0;
      if (rst) begin
        n_halt = 0; n_busy = 0; n_served = 0;
      end else if (m_halt) begin
        eh = 1; eew = ext_stall ? 0 : 2;
        if (resume) n_halt = 0;
      end else if (m_busy > 0) begin
        eew = ext_stall ? 0 : 2;
        if (!ext_stall) begin
          n_busy = m_busy - 1;
          if (n_busy == 0) n_served = 1;
        end
      end else if (ext_stall) begin
        eew = 0;
      end else if (de_stop) begin
        efd = 2; ede = 2; eew = 1; een = 1; esel = 3; n_halt = 1;
      end else if (de_wait_time != 0 && !m_served) begin
        eew = 2; n_busy = int'(de_wait_time) - 1;
        if (n_busy == 0) n_served = 1;
      end else if (e_redirect) begin
        efd = 2; ede = 2; eew = 1; een = 1; esel = 2;
      end else if (de_mem_read && (hit(d_rs) || hit(d_rt))) begin
        efd = 0; ede = 2; eew = 1;
      end else if (d_jump) begin
        efd = 2; ede = 1; eew = 1; een = 1; esel = 1;
      end else begin
        efd = 1; ede = 1; eew = 1; een = 1;
      end
      if (ede != 0) n_served = 0;
      check("model", pack(efd, ede, eew, een, esel, eh));
      @(posedge clk);
      m_halt = n_halt; m_busy = n_busy; m_served = n_served;
    end
  end

  initial begin
    logic [9:0] adv, stall, hlt, lu;
    adv = pack(1, 1, 1, 1, 0, 0);
    stall = pack(0, 0, 2, 0, 0, 0);
    hlt = pack(0, 0, 2, 0, 0, 1);
    lu = pack(0, 2, 1, 0, 0, 0);
    idle();
    #3 check("reset_outputs", '0);
    @(posedge clk); #1; rst = 0;
    chk("idle", adv);
    repeat (3) begin cyc(); chk("idle", adv); end
    cyc(); de_mem_read = 1; de_rw = 2'd1; de_rd = 5'd5; d_rs = 6'h05;
    chk("load_use_rs", lu);
    cyc(); d_rs = 6'h25;
    chk("load_use_other_file", adv);
    cyc(); d_rs = 6'h00; d_rt = 6'h05;
    chk("load_use_rt", lu);
    cyc(); idle(); de_wait_time = 5'd3;
    chk("wait3_c0", stall);
    cyc(); ext_stall = 1;
    chk("wait3_c1_ext", pack(0, 0, 0, 0, 0, 0));
    cyc(); ext_stall = 0;
    chk("wait3_c2", stall);
    cyc(); chk("wait3_c3", stall);
    cyc(); chk("wait3_c4_adv", adv);
    cyc(); idle(); de_wait_time = 5'd1;
    chk("wait1_c0", stall);
    cyc(); chk("wait1_c1_adv", adv);
    cyc(); idle(); e_redirect = 1; d_jump = 1; de_mem_read = 1; de_rw = 2'd1; de_rd = 5'd5; d_rs = 6'h05;
    chk("redirect_beats_lu", pack(2, 2, 1, 1, 2, 0));
    cyc(); idle(); d_jump = 1;
    chk("jump", pack(2, 1, 1, 1, 1, 0));
    cyc(); idle(); de_stop = 1; de_npc = 32'h240;
    chk("stop", pack(2, 2, 1, 1, 3, 0));
    cyc(); idle();
    chk("halt", hlt);
    repeat (10) begin cyc(); chk("halt_hold", hlt); end
    cyc(); ext_stall = 1;
    chk("halt_ext", pack(0, 0, 0, 0, 0, 1));
    cyc(); ext_stall = 0; resume = 1;
    chk("halt_resume_cycle", hlt);
    cyc(); resume = 0;
    chk("after_resume", adv);
    cyc(); de_wait_time = 5'd8;
    chk("wait8_c0", stall);
    cyc(); chk("wait8_c1", stall);
    cyc(); chk("wait8_c2", stall);
    #1 rst = 1;
    #1 check("reset_mid_wait", '0);
    cyc(); rst = 0;
    chk("wait8_restart_c0", stall);
    repeat (7) begin cyc(); chk("wait8_restart", stall); end
    cyc(); chk("wait8_restart_adv", adv);
    cyc(); idle();
    repeat (3000) begin
      cyc();
      rst = ($urandom_range(0, 299) == 0);
      d_rs = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))};
      d_rt = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))};
      de_rw = 2'($urandom_range(0, 3));
      de_rd = 5'($urandom_range(0, 3));
      de_mem_read = 1'($urandom_range(0, 1));
      d_jump = ($urandom_range(0, 5) == 0);
      e_redirect = ($urandom_range(0, 5) == 0);
      de_stop = ($urandom_range(0, 19) == 0);
      ext_stall = ($urandom_range(0, 7) == 0);
      resume = ($urandom_range(0, 3) == 0);
      de_wait_time = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 5)) : 5'd0;
      de_npc = $urandom;
    end
    cyc(); rst = 0; idle();
    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush controller for the 3-stage pipeline registers (fetch/decode, decode/execute, execute/writeback) and the PC.
- Each cycle it drives the 2-bit update code of every pipeline register, plus PC enable and PC source select.
- Inputs come from the decode stage, from the decode/execute register contents, and from the execute stage.
- Handles load-use stalls, multi-cycle execute waits, branch/jump flushes, stop/halt and external stalls.

Parameters:
- WAIT_W, 5, width of the multi-cycle wait count (matches de_wait_time).

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- d_rs  in  6  decode source s; bit5 = register-file select, [4:0] = index
- d_rt  in  6  decode source t; same encoding
- d_jump  in  1  unconditional jump resolved in decode
- de_rw  in  2  decode/execute write class; 0 = no write, bit1 = register-file select
- de_rd  in  5  decode/execute destination index
- de_mem_read  in  1  decode/execute instruction is a load (result not forwardable from execute)
- de_wait_time  in  WAIT_W  extra execute cycles required (0 = single-cycle)
- de_stop  in  1  stop instruction in execute
- de_npc  in  32  PC following the execute instruction (restart point after stop)
- e_redirect  in  1  execute resolved a taken branch or jr
- ext_stall  in  1  memory/IO busy; freeze everything
- resume  in  1  single-cycle pulse; leave HALT
- fd_update  out  2  update code for fetch/decode register
- de_update  out  2  update code for decode/execute register
- ew_update  out  2  update code for execute/writeback register
- pc_en  out  1  PC register load enable
- pc_sel  out  2  PC source: 0 = pc+4, 1 = decode jump target, 2 = execute target, 3 = de_npc
- halted  out  1  controller is in HALT

Behaviour:
- Update codes: 00 = hold, 01 = advance, 10 = flush to bubble. 11 is never driven.
- Outputs are combinational from state and inputs.
- While rst = 1, all outputs are 0 (updates 00, pc_en 0, pc_sel 0, halted 0), independent of clk.
- rst clears state to RUN, cnt to 0 and wait_done to 0. Reset asserted during WAIT or HALT aborts immediately.
- Hazard match: de_rw != 0 && de_rw[1] == rX[5] && de_rd == rX[4:0]. This is the same rule the forwarding unit uses.
- load_use = de_mem_read && (match on d_rs || match on d_rt).

State RUN, priority highest first:
1. ext_stall: fd 00, de 00, ew 00, pc_en 0. State and cnt unchanged.
2. de_stop: fd 10, de 10, ew 01, pc_en 1, pc_sel 3. Next state HALT.
3. de_wait_time = N != 0 and !wait_done: fd 00, de 00, ew 10, pc_en 0.
   - If N > 1: cnt <= N-1, next state WAIT.
   - If N = 1: wait_done <= 1, stay in RUN.
4. e_redirect: fd 10, de 10, ew 01, pc_en 1, pc_sel 2. Overrides load_use and d_jump.
5. load_use: fd 00, de 10, ew 01, pc_en 0.
6. d_jump: fd 10, de 01, ew 01, pc_en 1, pc_sel 1.
7. Otherwise: all 01, pc_en 1, pc_sel 0.
- wait_done clears on any cycle where de_update is 01 or 10.

State WAIT:
- Outputs: fd 00, de 00, ew 10, pc_en 0.
- cnt decrements when !ext_stall. When cnt == 1 and decrementing: next state RUN, wait_done <= 1.
- If ext_stall is high, ew is 00 instead and cnt is frozen.

Timing of a multi-cycle instruction:
- An execute instruction with wait N occupies decode/execute for exactly N+1 cycles, plus one cycle per ext_stall cycle.
- That is N stall cycles followed by the normal RUN decision.

State HALT:
- Outputs: fd 00, de 00, ew 10, pc_en 0, halted 1.
- resume: next state RUN. resume is ignored in other states.
- ext_stall in HALT: ew 00.

Decomposition:
- Shared package pipe_pkg holds:
  - update-code constants UPD_HOLD, UPD_ADV, UPD_FLUSH;
  - PC-select constants PCS_SEQ, PCS_JUMP, PCS_EXEC, PCS_NPC;
  - state enum ctrl_state_t {RUN, WAIT, HALT}.
- One combinational sub-module hazard_detect computes load_use from d_rs, d_rt, de_rw, de_rd and de_mem_read.

Test Plan:
1. Idle RUN, no hazards -> fd/de/ew = 01, pc_en 1, pc_sel 0 every cycle.
2. Load-use on matching file:
   - de_mem_read 1, de_rw 01, de_rd 5, d_rs 6'h05 -> fd 00, de 10, ew 01, pc_en 0.
   - Same with d_rs 6'h25 -> all 01 (different file, no stall).
3. Multi-cycle with external stall:
   - de_wait_time 3 at cycle 0 -> cycles 0-2 de 00, ew 10, pc_en 0; cycle 3 all 01.
   - ext_stall high in cycle 1 -> advance moves to cycle 4, ew 00 in cycle 1.
4. Branch beats load-use: e_redirect 1 with load_use 1 in the same cycle -> fd 10, de 10, ew 01, pc_en 1, pc_sel 2.
5. Stop and resume:
   - de_stop 1 -> pc_sel 3, pc_en 1, fd/de 10.
   - Next cycle halted 1 with holds, held over 10 cycles.
   - resume pulse -> following cycle RUN, all 01.
6. Reset mid-WAIT: de_wait_time 8, assert rst at cycle 2 -> outputs 0 immediately. After release, state RUN, wait_done 0, de_wait_time 8 restarts a full 8-cycle wait.
